// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbiter.
//   UART_INSTR_WRITE / UART_INSTR_NOP : instruction codes driven toward the UART controller
//   UART_BUF_DEPTH                    : UART write buffer depth (initial credit count)
//   arb_state_t                       : arbiter FSM state
package uart_pkg;

  localparam logic [2:0]  UART_INSTR_WRITE = 3'b011;
  localparam logic [2:0]  UART_INSTR_NOP   = 3'b000;
  localparam int unsigned UART_BUF_DEPTH   = 128;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans req_i starting at index ptr_i and wrapping, and returns the first requester found.
//   req_i      : request vector
//   ptr_i      : highest-priority index for this scan
//   pick_o     : one-hot winner (all zero when nothing requests)
//   pick_idx_o : binary index of the winner
//   found_o    : at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [PTR_W-1:0] pick_idx_o,
  output logic             found_o
);

  always_comb begin
    int unsigned       pos;
    logic [PTR_W-1:0]  idx;
    logic              hit;
    pick_o     = '0;
    pick_idx_o = '0;
    hit        = 1'b0;
    pos        = 0;
    idx        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = PTR_W'(pos);
      if (!hit && req_i[idx]) begin
        hit         = 1'b1;
        pick_o[idx] = 1'b1;
        pick_idx_o  = idx;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the single UART transmit write port among N_REQ requesters.
// Round-robin grant held for a whole packet, credit-based flow control against the UART
// write buffer, registered UART-side outputs (one byte per cycle, one cycle of latency).
//   clock, init_flag     : clock (rising edge), asynchronous active-low reset
//   req_valid/data/last  : per-requester byte offer (data packed 8 bits per requester)
//   req_ready            : combinational accept, transfer on valid & ready
//   byte_sent            : one-cycle pulse per byte drained by the UART (returns a credit)
//   UART_ENB/instruction/write_value : registered UART write port
//   grant                : registered one-hot owner, zero when idle
//   credits, credit_err  : free buffer slots, sticky credit overflow flag
//   timeout              : one-cycle pulse when an idle owner loses its grant
// Build option: define UART_ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX idle owner cycles;
// otherwise the grant is held until req_last and timeout is tied low.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DEPTH    = UART_BUF_DEPTH,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic                  clock,
  input  logic                  init_flag,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  byte_sent,
  output logic                  UART_ENB,
  output logic [2:0]            instruction,
  output logic [7:0]            write_value,
  output logic [N_REQ-1:0]      grant,
  output logic [CREDIT_W-1:0]   credits,
  output logic                  credit_err,
  output logic                  timeout
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam logic [CREDIT_W-1:0] CredFull = CREDIT_W'(DEPTH);

  arb_state_t           state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CREDIT_W-1:0]  credits_q, credits_d;
  logic                 credit_err_q, credit_err_d;
  logic                 enb_q, enb_d;
  logic [2:0]           instr_q, instr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 timeout_q, timeout_d;

  logic [N_REQ-1:0]     pick;
  logic [PTR_W-1:0]     pick_idx;
  logic                 found;

  logic                 own_valid, own_last, accept, release_lock, cred_inc;
  logic [7:0]           own_data;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .found_o    (found)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            hold_expired;

  // Credit stalls keep the owner valid, so only genuinely idle owner cycles count.
  assign hold_expired = (state_q == LOCKED) && !own_valid &&
                        (idle_cnt_q == CntW'(HOLD_MAX - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != LOCKED || accept || hold_expired) begin
      idle_cnt_d = '0;
    end else if (!own_valid) begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) idle_cnt_q <= '0;
    else            idle_cnt_q <= idle_cnt_d;
  end
`else
  logic hold_expired;
  logic unused_hold_max;
  assign hold_expired    = 1'b0;
  assign unused_hold_max = ^HOLD_MAX;
`endif

  // Owner's request lane.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == PTR_W'(k)) begin
        own_valid = req_valid[k];
        own_last  = req_last[k];
        own_data  = req_data[8*k +: 8];
      end
    end
  end

  assign accept       = (state_q == LOCKED) && own_valid && (credits_q != '0);
  assign release_lock = (accept && own_last) || hold_expired;
  // A drain pulse with a full buffer is bogus and must not push credits past DEPTH.
  assign cred_inc     = byte_sent && (credits_q != CredFull);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready    = '0;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[owner_q] = own_valid && (credits_q != '0);
        if (release_lock) begin
          grant_d   = '0;
          state_d   = IDLE;
          rr_ptr_d  = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
          timeout_d = hold_expired;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({accept, cred_inc})
      2'b10:   credits_d = credits_q - CREDIT_W'(1);
      2'b01:   credits_d = credits_q + CREDIT_W'(1);
      default: credits_d = credits_q;
    endcase
    credit_err_d = credit_err_q | (byte_sent && (credits_q == CredFull));
    enb_d        = accept;
    instr_d      = accept ? UART_INSTR_WRITE : UART_INSTR_NOP;
    wdata_d      = accept ? own_data : 8'h00;
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credits_q    <= CredFull;
      credit_err_q <= 1'b0;
      enb_q        <= 1'b0;
      instr_q      <= UART_INSTR_NOP;
      wdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      enb_q        <= enb_d;
      instr_q      <= instr_d;
      wdata_q      <= wdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign UART_ENB    = enb_q;
  assign instruction = instr_q;
  assign write_value = wdata_q;
  assign grant       = grant_q;
  assign credits     = credits_q;
  assign credit_err  = credit_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, DEPTH=128). Requester i sends byte value
// i*64 + (index of byte within its stream). Timeout case runs only with UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        init_flag;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        byte_sent;
  logic        UART_ENB;
  logic [2:0]  instruction;
  logic [7:0]  write_value;
  logic [7:0]  credits;
  logic        credit_err;
  logic        timeout;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          sent[4];
  int          tot[4];
  int          plen[4];
  logic [3:0]  en;
  logic [3:0]  take;
  logic [3:0]  last_gnt;
  logic [7:0]  wr_q[$];
  logic [3:0]  gnt_log[$];
  int          n;

  always #5 clock = ~clock;

  uart_tx_arbiter u_dut (
    .clock       (clock),
    .init_flag   (init_flag),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .byte_sent   (byte_sent),
    .UART_ENB    (UART_ENB),
    .instruction (instruction),
    .write_value (write_value),
    .grant       (grant),
    .credits     (credits),
    .credit_err  (credit_err),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = en[i] && (sent[i] < tot[i]);
      req_data[i*8 +: 8]  = 8'(i * 64 + sent[i]);
      req_last[i]         = ((sent[i] + 1) % plen[i]) == 0;
    end
  endtask

  // One clock: sample mid-cycle, then update requester models just after the edge.
  task automatic cycle();
    @(negedge clock);
    take = req_valid & req_ready;
    if (UART_ENB === 1'b1) wr_q.push_back(write_value);
    if (grant != 4'd0 && grant != last_gnt) gnt_log.push_back(grant);
    last_gnt = grant;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (take[i]) sent[i]++;
    byte_sent = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    init_flag = 1'b0;
    byte_sent = 1'b0;
    en        = '0;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      tot[i]  = 0;
      plen[i] = 1;
    end
    drive();
    cycle();
    cycle();
    init_flag = 1'b1;
    wr_q.delete();
    gnt_log.delete();
    last_gnt = '0;
  endtask

  initial begin
    last_gnt = '0;
    take     = '0;
    do_reset();

    // Reset state
    check("rst_grant", grant, 0);
    check("rst_enb", UART_ENB, 0);
    check("rst_instr", instruction, 0);
    check("rst_wval", write_value, 0);
    check("rst_credits", credits, 128);
    check("rst_cerr", credit_err, 0);
    check("rst_timeout", timeout, 0);

    // 1: reset mid-packet, then full resend
    en[0] = 1'b1; tot[0] = 3; plen[0] = 3;
    drive();
    n = 0;
    while (sent[0] != 2 && n < 20) begin cycle(); n++; end
    check("t1_pre_sent", sent[0], 2);
    check("t1_pre_grant", grant, 4'b0001);
    check("t1_pre_enb", UART_ENB, 1);
    check("t1_pre_instr", instruction, 3'b011);
    check("t1_pre_wval", write_value, 8'h01);
    check("t1_pre_credits", credits, 126);
    init_flag = 1'b0;
    #1;
    check("t1_async_grant", grant, 0);
    check("t1_async_enb", UART_ENB, 0);
    check("t1_async_instr", instruction, 0);
    check("t1_async_wval", write_value, 0);
    check("t1_async_credits", credits, 128);
    check("t1_async_ready", req_ready, 0);
    sent[0] = 0;
    drive();
    cycle();
    init_flag = 1'b1;
    wr_q.delete();
    gnt_log.delete();
    n = 0;
    while (sent[0] != 3 && n < 20) begin cycle(); n++; end
    cycle();
    cycle();
    check("t1_nwr", wr_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_data", wr_q[i], i);
    check("t1_regrant", gnt_log[0], 4'b0001);
    check("t1_end_grant", grant, 0);
    check("t1_credits", credits, 125);

    // 2: round-robin, 2-byte packets, one idle cycle between packets
    do_reset();
    en = 4'hf;
    for (int i = 0; i < 4; i++) begin tot[i] = 2; plen[i] = 2; end
    tot[0] = 4;
    drive();
    n = 0;
    while ((sent[0] + sent[1] + sent[2] + sent[3]) != 10 && n < 60) begin cycle(); n++; end
    check("t2_cycles", n, 15);
    cycle();
    cycle();
    begin
      logic [7:0] exp_wr[10];
      logic [3:0] exp_g[5];
      exp_wr = '{8'd0, 8'd1, 8'd64, 8'd65, 8'd128, 8'd129, 8'd192, 8'd193, 8'd2, 8'd3};
      exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      check("t2_nwr", wr_q.size(), 10);
      for (int i = 0; i < 10; i++) check("t2_data", wr_q[i], exp_wr[i]);
      check("t2_ngrants", gnt_log.size(), 5);
      for (int i = 0; i < 5; i++) check("t2_order", gnt_log[i], exp_g[i]);
    end

    // 3: credit exhaustion
    do_reset();
    en[1] = 1'b1; tot[1] = 130; plen[1] = 1000;
    drive();
    n = 0;
    while (sent[1] != 128 && n < 200) begin cycle(); n++; end
    cycle(); cycle(); cycle();
    check("t3_sent128", sent[1], 128);
    check("t3_credits0", credits, 0);
    check("t3_stall_ready", req_ready, 0);
    check("t3_grant_kept", grant, 4'b0010);
    check("t3_nwr128", wr_q.size(), 128);
    check("t3_first", wr_q[0], 8'd64);
    check("t3_last", wr_q[127], 8'd191);
    byte_sent = 1'b1;
    cycle();
    byte_sent = 1'b1;
    cycle();
    repeat (5) cycle();
    check("t3_sent130", sent[1], 130);
    check("t3_nwr130", wr_q.size(), 130);
    check("t3_wr129", wr_q[129], 8'd193);
    check("t3_credits_end", credits, 0);

    // 4: simultaneous accept + byte_sent, then overflow error
    do_reset();
    en[1] = 1'b1; tot[1] = 200; plen[1] = 1000;
    drive();
    n = 0;
    while (sent[1] != 123 && n < 200) begin cycle(); n++; end
    check("t4_credits5", credits, 5);
    byte_sent = 1'b1;
    cycle();
    check("t4_both_sent", sent[1], 124);
    check("t4_both_credits", credits, 5);
    en[1] = 1'b0;
    drive();
    byte_sent = 1'b1;
    cycle();
    check("t4_inc", credits, 6);
    check("t4_no_err", credit_err, 0);
    do_reset();
    byte_sent = 1'b1;
    cycle();
    check("t4_err_set", credit_err, 1);
    check("t4_full_credits", credits, 128);
    cycle();
    check("t4_err_sticky", credit_err, 1);

    // 5: lock held while owner pauses
    do_reset();
    en[2] = 1'b1; tot[2] = 4; plen[2] = 4;
    en[3] = 1'b1; tot[3] = 2; plen[3] = 2;
    drive();
    n = 0;
    while (sent[2] != 2 && n < 20) begin cycle(); n++; end
    en[2] = 1'b0;
    drive();
    repeat (10) cycle();
    check("t5_no_req3", sent[3], 0);
    check("t5_grant", grant, 4'b0100);
    check("t5_enb_low", UART_ENB, 0);
    en[2] = 1'b1;
    drive();
    n = 0;
    while (sent[2] != 4 && n < 20) begin cycle(); n++; end
    n = 0;
    while (sent[3] != 2 && n < 20) begin cycle(); n++; end
    cycle();
    cycle();
    check("t5_nwr", wr_q.size(), 6);
    check("t5_wr3", wr_q[3], 8'd131);
    check("t5_wr4", wr_q[4], 8'd192);
    check("t5_wr5", wr_q[5], 8'd193);
    check("t5_g0", gnt_log[0], 4'b0100);
    check("t5_g1", gnt_log[1], 4'b1000);

`ifdef UART_ARB_TIMEOUT_EN
    // 6: idle owner loses the grant after 64 cycles
    do_reset();
    en[2] = 1'b1; tot[2] = 1; plen[2] = 1000;
    en[3] = 1'b1; tot[3] = 1; plen[3] = 1;
    drive();
    n = 0;
    while (sent[2] != 1 && n < 20) begin cycle(); n++; end
    check("t6_timeout_low", timeout, 0);
    n = 0;
    do begin cycle(); n++; end while (grant != 4'd0 && n < 100);
    check("t6_idle_cycles", n, 64);
    check("t6_pulse", timeout, 1);
    cycle();
    check("t6_pulse_end", timeout, 0);
    check("t6_grant3", grant, 4'b1000);
`else
    check("t6_timeout_tied", timeout, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
